// File: rtl/wb_writeback_unit.sv
// rtl/wb_writeback_unit.sv - writeback stage: scalar/vector RF write ports, 3-beat vector FSM, forwarding view
module wb_writeback_unit #(
    parameter int VEC_W  = 192,
    parameter int SCA_W  = 21,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        wb_in,
    input  logic [VEC_W-1:0]  muxMem_in,
    input  logic [SCA_W-1:0]  resALUe_in,
    input  logic [VEC_W-1:0]  memData_in,
    input  logic [ADDR_W-1:0] dest_in,
    input  logic              destType_in,
    output logic              busy,
    output logic              sreg_we,
    output logic [ADDR_W-1:0] sreg_addr,
    output logic [SCA_W-1:0]  sreg_data,
    output logic              vreg_we,
    output logic [ADDR_W-1:0] vreg_addr,
    output logic [1:0]        vreg_beat,
    output logic [BEAT_W-1:0] vreg_data,
    output logic              fwd_valid,
    output logic              fwd_type,
    output logic [ADDR_W-1:0] fwd_dest,
    output logic [VEC_W-1:0]  fwd_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_VB1  = 2'd1,
        S_VB2  = 2'd2
    } state_t;

    state_t              state_q;
    logic [VEC_W-1:0]    hold_q;
    logic [ADDR_W-1:0]   hold_dest_q;

    logic                reg_write;
    logic                mem_to_reg;
    logic [VEC_W-1:0]    vec_res_d;
    logic [SCA_W-1:0]    sca_res_d;
    logic [VEC_W-1:0]    sca_ext_d;

    assign reg_write  = wb_in[0];
    assign mem_to_reg = wb_in[1];

    // The upstream MEM/WB register is held for as long as a vector write is still in its later beats
    assign busy = (state_q != S_IDLE);

    // Result selection between the ALU/mux path and the memory load path
    always_comb begin
        vec_res_d = mem_to_reg ? memData_in : muxMem_in;
        sca_res_d = mem_to_reg ? memData_in[SCA_W-1:0] : resALUe_in;
        sca_ext_d = {{(VEC_W-SCA_W){1'b0}}, sca_res_d};
    end

    // Writeback FSM with registered RF and forwarding outputs; updates on negedge like the pipe registers
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_dest_q <= '0;
            sreg_we     <= 1'b0;
            sreg_addr   <= '0;
            sreg_data   <= '0;
            vreg_we     <= 1'b0;
            vreg_addr   <= '0;
            vreg_beat   <= 2'd0;
            vreg_data   <= '0;
            fwd_valid   <= 1'b0;
            fwd_type    <= 1'b0;
            fwd_dest    <= '0;
            fwd_data    <= '0;
        end else begin
            // Strobes default low; address/data/type keep their last value
            sreg_we   <= 1'b0;
            vreg_we   <= 1'b0;
            fwd_valid <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (reg_write) begin
                        fwd_valid <= 1'b1;
                        fwd_dest  <= dest_in;
                        if (!destType_in) begin
                            sreg_we   <= 1'b1;
                            sreg_addr <= dest_in;
                            sreg_data <= sca_res_d;
                            fwd_type  <= 1'b0;
                            fwd_data  <= sca_ext_d;
                        end else begin
                            hold_q      <= vec_res_d;
                            hold_dest_q <= dest_in;
                            vreg_we     <= 1'b1;
                            vreg_addr   <= dest_in;
                            vreg_beat   <= 2'd0;
                            vreg_data   <= vec_res_d[BEAT_W-1:0];
                            fwd_type    <= 1'b1;
                            fwd_data    <= vec_res_d;
                            state_q     <= S_VB1;
                        end
                    end
                end
                S_VB1: begin
                    // Forwarding keeps presenting the full held result across every beat
                    vreg_we   <= 1'b1;
                    vreg_addr <= hold_dest_q;
                    vreg_beat <= 2'd1;
                    vreg_data <= hold_q[2*BEAT_W-1:BEAT_W];
                    fwd_valid <= 1'b1;
                    state_q   <= S_VB2;
                end
                S_VB2: begin
                    vreg_we   <= 1'b1;
                    vreg_addr <= hold_dest_q;
                    vreg_beat <= 2'd2;
                    vreg_data <= hold_q[3*BEAT_W-1:2*BEAT_W];
                    fwd_valid <= 1'b1;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_writeback_unit.sv
// tb/tb_wb_writeback_unit.sv - table-driven bench for wb_writeback_unit
module tb_wb_writeback_unit;

    localparam int VEC_W  = 192;
    localparam int SCA_W  = 21;
    localparam int BEAT_W = 64;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              rst;
    logic [1:0]        wb_in;
    logic [VEC_W-1:0]  muxMem_in;
    logic [SCA_W-1:0]  resALUe_in;
    logic [VEC_W-1:0]  memData_in;
    logic [ADDR_W-1:0] dest_in;
    logic              destType_in;
    logic              busy;
    logic              sreg_we;
    logic [ADDR_W-1:0] sreg_addr;
    logic [SCA_W-1:0]  sreg_data;
    logic              vreg_we;
    logic [ADDR_W-1:0] vreg_addr;
    logic [1:0]        vreg_beat;
    logic [BEAT_W-1:0] vreg_data;
    logic              fwd_valid;
    logic              fwd_type;
    logic [ADDR_W-1:0] fwd_dest;
    logic [VEC_W-1:0]  fwd_data;

    wb_writeback_unit #(
        .VEC_W (VEC_W),
        .SCA_W (SCA_W),
        .BEAT_W(BEAT_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_in      (wb_in),
        .muxMem_in  (muxMem_in),
        .resALUe_in (resALUe_in),
        .memData_in (memData_in),
        .dest_in    (dest_in),
        .destType_in(destType_in),
        .busy       (busy),
        .sreg_we    (sreg_we),
        .sreg_addr  (sreg_addr),
        .sreg_data  (sreg_data),
        .vreg_we    (vreg_we),
        .vreg_addr  (vreg_addr),
        .vreg_beat  (vreg_beat),
        .vreg_data  (vreg_data),
        .fwd_valid  (fwd_valid),
        .fwd_type   (fwd_type),
        .fwd_dest   (fwd_dest),
        .fwd_data   (fwd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]        wb;
        logic              dt;
        logic [ADDR_W-1:0] dest;
        logic [VEC_W-1:0]  mux;
        logic [SCA_W-1:0]  alu;
        logic [VEC_W-1:0]  mem;
        logic              e_busy;
        logic              e_swe;
        logic [ADDR_W-1:0] e_saddr;
        logic [SCA_W-1:0]  e_sdata;
        logic              e_vwe;
        logic [ADDR_W-1:0] e_vaddr;
        logic [1:0]        e_beat;
        logic [BEAT_W-1:0] e_vdata;
        logic              e_fv;
        logic              e_ft;
        logic [ADDR_W-1:0] e_fd;
        logic [VEC_W-1:0]  e_fdata;
    } vec_t;

    localparam logic [63:0] BA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] BB = 64'hBBBB_BBBB_BBBB_BBBB;
    localparam logic [63:0] BC = 64'hCCCC_CCCC_CCCC_CCCC;
    localparam logic [63:0] M0 = 64'h0F1E_2D3C_4B5A_6978;
    localparam logic [63:0] M1 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] M2 = 64'h0123_4567_89AB_CDEF;

    int n_vec;
    int n_err;
    vec_t tbl[13];

    function automatic vec_t in_row(input logic [1:0] wb, input logic dt, input logic [ADDR_W-1:0] dest,
                                    input logic [VEC_W-1:0] mux, input logic [SCA_W-1:0] alu,
                                    input logic [VEC_W-1:0] mem);
        vec_t v;
        v = '{default: '0};
        v.wb = wb; v.dt = dt; v.dest = dest; v.mux = mux; v.alu = alu; v.mem = mem;
        return v;
    endfunction

    function automatic vec_t ex_s(input vec_t vi, input logic [ADDR_W-1:0] addr, input logic [SCA_W-1:0] data);
        vec_t v;
        v = vi;
        v.e_swe = 1'b1; v.e_saddr = addr; v.e_sdata = data;
        v.e_fv = 1'b1; v.e_ft = 1'b0; v.e_fd = addr; v.e_fdata = {{(VEC_W-SCA_W){1'b0}}, data};
        return v;
    endfunction

    function automatic vec_t ex_v(input vec_t vi, input logic bsy, input logic [ADDR_W-1:0] addr,
                                  input logic [1:0] beat, input logic [BEAT_W-1:0] data,
                                  input logic [VEC_W-1:0] full);
        vec_t v;
        v = vi;
        v.e_busy = bsy; v.e_vwe = 1'b1; v.e_vaddr = addr; v.e_beat = beat; v.e_vdata = data;
        v.e_fv = 1'b1; v.e_ft = 1'b1; v.e_fd = addr; v.e_fdata = full;
        return v;
    endfunction

    task automatic chk(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] wb, input logic dt, input logic [ADDR_W-1:0] dest,
                         input logic [VEC_W-1:0] mux, input logic [SCA_W-1:0] alu, input logic [VEC_W-1:0] mem);
        rst = r; wb_in = wb; destType_in = dt; dest_in = dest;
        muxMem_in = mux; resALUe_in = alu; memData_in = mem;
        @(negedge clk);
        @(posedge clk);
    endtask

    function automatic logic [VEC_W-1:0] rnd_vec();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    logic [VEC_W-1:0] vload;
    logic [VEC_W-1:0] muxv;

    initial begin
        n_vec = 0;
        n_err = 0;
        vload = {BC, BB, BA};
        muxv  = {M2, M1, M0};

        // Reset for two edges with a vector write presented: reset must win
        drive(1'b1, 2'b01, 1'b1, 3'd6, rnd_vec(), SCA_W'($urandom()), rnd_vec());
        drive(1'b1, 2'(1 + $urandom_range(0, 2)), 1'($urandom()), 3'($urandom()), rnd_vec(), SCA_W'($urandom()), rnd_vec());
        chk("rst busy", busy, 1'b0);
        chk("rst sreg_we", sreg_we, 1'b0);
        chk("rst vreg_we", vreg_we, 1'b0);
        chk("rst fwd_valid", fwd_valid, 1'b0);
        chk("rst vreg_beat", vreg_beat, 2'd0);
        chk("rst vreg_data", vreg_data, '0);
        chk("rst fwd_data", fwd_data, '0);

        tbl[0]  = ex_s(in_row(2'b01, 1'b0, 3'd5, ~vload, 21'h1ABCDE, vload), 3'd5, 21'h1ABCDE);
        tbl[1]  = in_row(2'b00, 1'b0, 3'd1, muxv, 21'h0FFFFF, vload);
        tbl[2]  = ex_s(in_row(2'b11, 1'b0, 3'd2, muxv, 21'h155555, {128'h0, 64'hFFFF_FFFF_FFE0_F00F}), 3'd2, 21'h00F00F);
        tbl[3]  = in_row(2'b10, 1'b1, 3'd4, muxv, 21'h000001, vload);
        tbl[4]  = ex_v(in_row(2'b11, 1'b1, 3'd3, ~vload, 21'h000002, vload), 1'b1, 3'd3, 2'd0, BA, vload);
        tbl[5]  = ex_v(in_row(2'b01, 1'b0, 3'd7, muxv, 21'h000123, muxv), 1'b1, 3'd3, 2'd1, BB, vload);
        tbl[6]  = ex_v(in_row(2'b01, 1'b1, 3'd6, muxv, 21'h000123, muxv), 1'b0, 3'd3, 2'd2, BC, vload);
        tbl[7]  = ex_s(in_row(2'b01, 1'b0, 3'd7, muxv, 21'h000123, vload), 3'd7, 21'h000123);
        tbl[8]  = ex_v(in_row(2'b01, 1'b1, 3'd0, muxv, 21'h000456, vload), 1'b1, 3'd0, 2'd0, M0, muxv);
        tbl[9]  = ex_v(in_row(2'b01, 1'b0, 3'd4, vload, 21'h1FFFFF, muxv), 1'b1, 3'd0, 2'd1, M1, muxv);
        tbl[10] = ex_v(in_row(2'b01, 1'b0, 3'd4, vload, 21'h1FFFFF, muxv), 1'b0, 3'd0, 2'd2, M2, muxv);
        tbl[11] = ex_s(in_row(2'b01, 1'b0, 3'd4, vload, 21'h1FFFFF, muxv), 3'd4, 21'h1FFFFF);
        tbl[12] = in_row(2'b00, 1'b1, 3'd2, vload, 21'h000000, muxv);

        for (int i = 0; i < 13; i++) begin
            drive(1'b0, tbl[i].wb, tbl[i].dt, tbl[i].dest, tbl[i].mux, tbl[i].alu, tbl[i].mem);
            chk($sformatf("v%0d busy", i), busy, tbl[i].e_busy);
            chk($sformatf("v%0d sreg_we", i), sreg_we, tbl[i].e_swe);
            chk($sformatf("v%0d vreg_we", i), vreg_we, tbl[i].e_vwe);
            chk($sformatf("v%0d fwd_valid", i), fwd_valid, tbl[i].e_fv);
            if (tbl[i].e_swe) begin
                chk($sformatf("v%0d sreg_addr", i), sreg_addr, tbl[i].e_saddr);
                chk($sformatf("v%0d sreg_data", i), sreg_data, tbl[i].e_sdata);
            end
            if (tbl[i].e_vwe) begin
                chk($sformatf("v%0d vreg_addr", i), vreg_addr, tbl[i].e_vaddr);
                chk($sformatf("v%0d vreg_beat", i), vreg_beat, tbl[i].e_beat);
                chk($sformatf("v%0d vreg_data", i), vreg_data, tbl[i].e_vdata);
            end
            if (tbl[i].e_fv) begin
                chk($sformatf("v%0d fwd_type", i), fwd_type, tbl[i].e_ft);
                chk($sformatf("v%0d fwd_dest", i), fwd_dest, tbl[i].e_fd);
                chk($sformatf("v%0d fwd_data", i), fwd_data, tbl[i].e_fdata);
            end
        end

        // Reset on the edge after beat 0 aborts the remaining beats
        drive(1'b0, 2'b01, 1'b1, 3'd1, vload, 21'h0, muxv);
        chk("abort beat0 vreg_we", vreg_we, 1'b1);
        chk("abort beat0 data", vreg_data, BA);
        drive(1'b1, 2'b11, 1'b1, 3'd5, rnd_vec(), SCA_W'($urandom()), rnd_vec());
        chk("abort vreg_we", vreg_we, 1'b0);
        chk("abort busy", busy, 1'b0);
        chk("abort fwd_valid", fwd_valid, 1'b0);
        chk("abort vreg_beat", vreg_beat, 2'd0);
        chk("abort vreg_addr", vreg_addr, 3'd0);
        chk("abort fwd_data", fwd_data, '0);
        drive(1'b0, 2'b01, 1'b0, 3'd6, vload, 21'h0ABCDE, muxv);
        chk("post sreg_we", sreg_we, 1'b1);
        chk("post sreg_addr", sreg_addr, 3'd6);
        chk("post sreg_data", sreg_data, 21'h0ABCDE);
        chk("post vreg_we", vreg_we, 1'b0);
        chk("post fwd_dest", fwd_dest, 3'd6);
        drive(1'b0, 2'b00, 1'b0, 3'd0, vload, 21'h0, muxv);
        chk("post2 vreg_we", vreg_we, 1'b0);
        chk("post2 sreg_we", sreg_we, 1'b0);
        chk("post2 busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_writeback_unit.md
Name: wb_writeback_unit

Overview:
- Writeback stage that consumes the MEM/WB pipe register outputs: selects ALU or memory result and drives the scalar and vector register-file write ports.
- Vector results (192 bit) are written through a 64-bit vector RF port in 3 beats under FSM control; upstream is held with a busy flag.
- Also provides a forwarding view of the in-flight write for the hazard unit.

Parameters:
- VEC_W, 192, vector result width
- SCA_W, 21, scalar result width
- BEAT_W, 64, vector RF write-port width; VEC_W/BEAT_W = 3 beats
- ADDR_W, 3, register index width

Ports:
- clk  in  1  clock; all state updates on negedge clk, same as the pipe registers
- rst  in  1  synchronous, active-high reset
- wb_in  in  2  bit0 = reg_write, bit1 = mem_to_reg
- muxMem_in  in  VEC_W  vector ALU/mux result
- resALUe_in  in  SCA_W  scalar ALU result
- memData_in  in  VEC_W  memory read data
- dest_in  in  ADDR_W  destination register
- destType_in  in  1  0 = scalar RF, 1 = vector RF
- busy  out  1  writeback occupied; upstream holds MEM/WB contents
- sreg_we  out  1  scalar RF write enable
- sreg_addr  out  ADDR_W  scalar RF address
- sreg_data  out  SCA_W  scalar RF data
- vreg_we  out  1  vector RF write enable
- vreg_addr  out  ADDR_W  vector RF address
- vreg_beat  out  2  beat index 0..2
- vreg_data  out  BEAT_W  beat data
- fwd_valid  out  1  a write is being issued this cycle
- fwd_type  out  1  type of forwarded write
- fwd_dest  out  ADDR_W  destination of forwarded write
- fwd_data  out  VEC_W  full result; scalar zero-extended

Behaviour:
- Data select: vector result = mem_to_reg ? memData_in : muxMem_in. Scalar result = mem_to_reg ? memData_in[SCA_W-1:0] : resALUe_in.
- FSM states: IDLE, VB1, VB2. busy = 1 in VB1 and VB2, 0 in IDLE; busy is derived from the registered state.
- In IDLE, inputs are sampled on every negedge:
  - reg_write = 0: bubble. All we = 0, fwd_valid = 0, stay IDLE.
  - Scalar (destType_in = 0): sreg_we = 1 with addr and data for exactly 1 cycle; fwd_valid = 1 for that cycle; stay IDLE. Latency is 1 edge.
  - Vector (destType_in = 1): capture the 192-bit result and dest into a hold register. Issue beat 0 (bits 63:0, vreg_beat = 0, vreg_we = 1). Go to VB1.
- VB1 -> VB2: issue beat 1 (bits 127:64).
- VB2 -> IDLE: issue beat 2 (bits 191:128).
- Input handling while busy:
  - Inputs are ignored in VB1 and VB2.
  - The next instruction is sampled on the first edge after the return to IDLE.
  - Vector write occupancy is 3 cycles.
- fwd_* during a vector write:
  - Reflect the held result for all 3 beat cycles (fwd_valid = 1, fwd_type = 1).
  - Forwarding is valid from the beat-0 cycle onward, before the RF contents are complete.
- Outputs are registered. In any cycle with no write, sreg_we, vreg_we and fwd_valid are 0. Address/data outputs hold their last value; consumers must not rely on them.
- sreg_we and vreg_we are never 1 in the same cycle.
- Reset (rst = 1 at a negedge):
  - State = IDLE; busy, sreg_we, vreg_we, fwd_valid = 0.
  - All address, data, beat, type and hold registers = 0.
  - Reset mid-vector aborts the write; remaining beats are dropped and no further vreg_we occurs.
  - rst has priority over any input sampled on that edge.
- wb_in bit1 with bit0 = 0 has no effect.
- dest 0 is writable; no hard-wired zero register.

Test Plan:
- Reset: rst = 1 for 2 negedges with random inputs -> busy = sreg_we = vreg_we = fwd_valid = 0, vreg_beat = 0.
- Scalar ALU write: wb_in = 01, destType = 0, dest = 5, resALUe = 0x1ABCDE -> next cycle sreg_we = 1, sreg_addr = 5, sreg_data = 0x1ABCDE, fwd_valid = 1; the following cycle sreg_we = 0.
- Scalar load: wb_in = 11, destType = 0, memData[20:0] = 0x00F00F -> sreg_data = 0x00F00F; resALUe is ignored.
- Vector load: wb_in = 11, destType = 1, dest = 3, memData = {64'hC..C, 64'hB..B, 64'hA..A}.
  - Expect 3 consecutive cycles with vreg_we = 1, vreg_addr = 3, beats 0/1/2 carrying A..A, B..B, C..C.
  - busy = 1 during beats 1 and 2; new inputs presented during that time are ignored.
  - The next scalar write appears the cycle after beat 2.
- Bubble and mixed stream: sequence of wb_in = 00, then a vector op, then a scalar op held stable until busy = 0.
  - Expect no write for the bubble.
  - Expect the vector write as 3 beats, then exactly one sreg_we, with fwd_dest tracking each write.
- Reset mid-vector: assert rst on the edge after beat 0 -> no beat 1 or 2, busy = 0, and the module accepts a new op the cycle after rst deasserts.
